// File: rtl/branch_defs.sv
// Shared definitions for the branch resolver: funct3 encodings, FSM states, counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package branch_defs;

   // Performance counter width
   localparam int CNT_W = 32;

   // Conditional branch funct3 encodings
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_RSV2 = 3'b010;
   localparam logic [2:0] F3_RSV3 = 3'b011;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Resolver FSM states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   // Unsigned compares are the only ones that switch the comparator out of signed mode
   function automatic logic signed_sel(input logic [2:0] f3);
      return !((f3 == F3_BLTU) || (f3 == F3_BGEU));
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode: comparator mode select, taken decision, illegal-encoding detect.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle from the current funct3 and comparator flags.
module branch_cond
   import branch_defs::*;
(
   input  logic [2:0] funct3,
   input  logic       eq,
   input  logic       lt,
   output logic       s,
   output logic       cond_taken,
   output logic       cond_illegal
);

   // Comparator mode depends only on the encoding, not on the op type
   assign s = signed_sel(funct3);

   // Map the funct3 encoding onto the comparator flags
   always_comb begin
      cond_taken   = 1'b0;
      cond_illegal = 1'b0;
      case (funct3)
         F3_BEQ:           cond_taken = eq;
         F3_BNE:           cond_taken = !eq;
         F3_BLT, F3_BLTU:  cond_taken = lt;
         F3_BGE, F3_BGEU:  cond_taken = !lt;
         F3_RSV2, F3_RSV3: cond_illegal = 1'b1;
         default:          cond_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// Resolves branch/JAL/JALR ops into fetch redirects, then squashes younger work for KILL_CYCLES.
// Latency: redirect_valid rises one cycle after acceptance; misaligned/illegal pulse one cycle after.
// Backpressure: in_ready only in IDLE; redirect held until redirect_ready. Counters need BRANCH_PERF_EN.
module branch_resolver
   import branch_defs::*;
#(
   parameter int KILL_CYCLES = 2
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_branch,
   input  logic             is_jal,
   input  logic             is_jalr,
   input  logic [2:0]       funct3,
   input  logic [31:0]      pc,
   input  logic [31:0]      imm,
   input  logic [31:0]      rs1d,
   output logic             s,
   input  logic             eq,
   input  logic             lt,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [31:0]      redirect_pc,
   output logic             kill,
   output logic             misaligned,
   output logic             illegal_branch,
   output logic [CNT_W-1:0] resolved_count,
   output logic [CNT_W-1:0] taken_count
);

   // Load value for the flush down-counter; FLUSH exits when it reaches zero
   localparam logic [2:0] KILL_LOAD = (KILL_CYCLES > 0) ? 3'(KILL_CYCLES - 1) : 3'd0;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  kill_cnt;
   logic        cond_taken;
   logic        cond_illegal;
   logic        accept;
   logic        op_any;
   logic        taken;
   logic [31:0] pc_sum;
   logic [31:0] jalr_sum;
   logic [31:0] target;
   logic        do_redirect;
   logic        do_misaligned;
   logic        do_illegal;
   logic        handshake;

   branch_cond u_cond (
      .funct3       (funct3),
      .eq           (eq),
      .lt           (lt),
      .s            (s),
      .cond_taken   (cond_taken),
      .cond_illegal (cond_illegal)
   );

   // Target arithmetic wraps naturally at 32 bits; JALR drops bit 0 of its sum
   assign pc_sum   = pc + imm;
   assign jalr_sum = rs1d + imm;
   assign target   = is_jalr ? {jalr_sum[31:1], 1'b0} : pc_sum;

   // Ops with no type bit set are consumed but have no effect anywhere
   assign in_ready      = reset_n && (state == IDLE);
   assign accept        = in_valid && in_ready;
   assign op_any        = is_branch || is_jal || is_jalr;
   assign taken         = is_jal || is_jalr || (is_branch && cond_taken);
   assign do_redirect   = accept && op_any && taken && !target[1];
   assign do_misaligned = accept && op_any && taken && target[1];
   assign do_illegal    = accept && is_branch && cond_illegal;
   assign handshake     = (state == REDIRECT) && redirect_ready;

   assign redirect_valid = (state == REDIRECT);
   assign kill           = (state == FLUSH);

   // State register; reset aborts any redirect or flush in progress
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (do_redirect) state_nxt = REDIRECT;
         end
         REDIRECT: begin
            if (redirect_ready) state_nxt = (KILL_CYCLES > 0) ? FLUSH : IDLE;
         end
         FLUSH: begin
            if (kill_cnt == 3'd0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Flush length counter, loaded on the redirect handshake
   always_ff @(posedge clk) begin
      if (!reset_n)                                  kill_cnt <= 3'd0;
      else if (handshake)                            kill_cnt <= KILL_LOAD;
      else if (state == FLUSH && kill_cnt != 3'd0)   kill_cnt <= kill_cnt - 3'd1;
   end

   // Redirect target capture; held stable while fetch stalls
   always_ff @(posedge clk) begin
      if (!reset_n)         redirect_pc <= 32'd0;
      else if (do_redirect) redirect_pc <= target;
   end

   // One-cycle exception pulses following acceptance
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         misaligned     <= 1'b0;
         illegal_branch <= 1'b0;
      end else begin
         misaligned     <= do_misaligned;
         illegal_branch <= do_illegal;
      end
   end

`ifdef BRANCH_PERF_EN
   logic [CNT_W-1:0] resolved_q;
   logic [CNT_W-1:0] taken_q;

   // Performance counters: every accepted typed op, and the taken subset (misaligned included)
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         resolved_q <= '0;
         taken_q    <= '0;
      end else if (accept && op_any) begin
         resolved_q <= resolved_q + 1'b1;
         if (taken) taken_q <= taken_q + 1'b1;
      end
   end

   assign resolved_count = resolved_q;
   assign taken_count    = taken_q;
`else
   assign resolved_count = '0;
   assign taken_count    = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized traffic vs a reference model.
// Latency: model predicts outputs per cycle; compared on every falling edge.
// Backpressure: exercises stalled redirects and in_valid during busy periods.
module tb_branch_resolver;

   localparam int KC = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        is_branch = 1'b0;
   logic        is_jal = 1'b0;
   logic        is_jalr = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] pc = 32'd0;
   logic [31:0] imm = 32'd0;
   logic [31:0] rs1d = 32'd0;
   logic        s;
   logic        eq = 1'b0;
   logic        lt = 1'b0;
   logic        redirect_valid;
   logic        redirect_ready = 1'b1;
   logic [31:0] redirect_pc;
   logic        kill;
   logic        misaligned;
   logic        illegal_branch;
   logic [31:0] resolved_count;
   logic [31:0] taken_count;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   branch_resolver #(.KILL_CYCLES(KC)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .is_branch      (is_branch),
      .is_jal         (is_jal),
      .is_jalr        (is_jalr),
      .funct3         (funct3),
      .pc             (pc),
      .imm            (imm),
      .rs1d           (rs1d),
      .s              (s),
      .eq             (eq),
      .lt             (lt),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .kill           (kill),
      .misaligned     (misaligned),
      .illegal_branch (illegal_branch),
      .resolved_count (resolved_count),
      .taken_count    (taken_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   bit          m_redir_pending;   // a redirect is waiting for fetch
   int          m_kill_left;       // remaining squash cycles
   logic [31:0] m_rpc;
   bit          m_mis;
   bit          m_ill;
   logic [31:0] m_res;
   logic [31:0] m_tak;

   initial begin
      m_redir_pending = 0; m_kill_left = 0; m_rpc = 0;
      m_mis = 0; m_ill = 0; m_res = 0; m_tak = 0;
   end

   function automatic bit model_taken(input logic [2:0] f3, input logic e, input logic l);
      case (f3)
         3'd0: return e;
         3'd1: return !e;
         3'd4, 3'd6: return l;
         3'd5, 3'd7: return !l;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin
      bit          busy;
      bit          tk;
      logic [31:0] tgt;
      busy = m_redir_pending || (m_kill_left > 0);
      if (!reset_n) begin
         m_redir_pending = 0; m_kill_left = 0; m_rpc = 0;
         m_mis = 0; m_ill = 0; m_res = 0; m_tak = 0;
      end else begin
         m_mis = 0;
         m_ill = 0;
         if (m_redir_pending) begin
            if (redirect_ready) begin
               m_redir_pending = 0;
               m_kill_left = KC;
            end
         end else if (m_kill_left > 0) begin
            m_kill_left = m_kill_left - 1;
         end
         if (!busy && in_valid && (is_branch || is_jal || is_jalr)) begin
            tk  = is_jal || is_jalr || model_taken(funct3, eq, lt);
            tgt = is_jalr ? ((rs1d + imm) & 32'hFFFF_FFFE) : (pc + imm);
            if (is_branch && (funct3 == 3'd2 || funct3 == 3'd3)) m_ill = 1;
            m_res = m_res + 1;
            if (tk) begin
               m_tak = m_tak + 1;
               if (tgt[1]) m_mis = 1;
               else begin
                  m_redir_pending = 1;
                  m_rpc = tgt;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", {31'd0, in_ready},
               {31'd0, reset_n && !m_redir_pending && (m_kill_left == 0)});
         check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir_pending});
         check("redirect_pc", redirect_pc, m_rpc);
         check("kill", {31'd0, kill}, {31'd0, m_kill_left > 0});
         check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
         check("illegal_branch", {31'd0, illegal_branch}, {31'd0, m_ill});
         check("s", {31'd0, s}, {31'd0, !(funct3 == 3'd6 || funct3 == 3'd7)});
`ifdef BRANCH_PERF_EN
         check("resolved_count", resolved_count, m_res);
         check("taken_count", taken_count, m_tak);
`else
         check("resolved_count", resolved_count, 32'd0);
         check("taken_count", taken_count, 32'd0);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      check("idle_reached", {31'd0, ok}, 32'd1);
   endtask

   // kind: 0 branch, 1 JAL, 2 JALR. Returns at accept edge + 2.
   task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] t_pc,
                        input logic [31:0] t_imm, input logic [31:0] t_rs1,
                        input logic t_eq, input logic t_lt);
      @(posedge clk); #2;
      in_valid  = 1'b1;
      is_branch = (kind == 0);
      is_jal    = (kind == 1);
      is_jalr   = (kind == 2);
      funct3    = f3;
      pc        = t_pc;
      imm       = t_imm;
      rs1d      = t_rs1;
      eq        = t_eq;
      lt        = t_lt;
      @(posedge clk); #2;
      in_valid  = 1'b0;
   endtask

   initial begin
      // Reset
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_kill", {31'd0, kill}, 32'd0);
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // BEQ taken, fetch ready immediately
      redirect_ready = 1'b1;
      do_op(0, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      check("beq_rv", {31'd0, redirect_valid}, 32'd1);
      check("beq_rpc", redirect_pc, 32'h120);
      @(negedge clk);
      check("beq_kill1", {31'd0, kill}, 32'd1);
      @(negedge clk);
      check("beq_kill2", {31'd0, kill}, 32'd1);
      @(negedge clk);
      check("beq_kill_done", {31'd0, kill}, 32'd0);
      check("beq_ready", {31'd0, in_ready}, 32'd1);

      // BLTU not taken
      do_op(0, 3'b110, 32'h400, 32'h80, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      check("bltu_s", {31'd0, s}, 32'd0);
      check("bltu_no_rv", {31'd0, redirect_valid}, 32'd0);
      check("bltu_ready", {31'd0, in_ready}, 32'd1);

      // JALR bit 0 cleared, then misaligned JALR
      do_op(2, 3'b000, 32'h0, 32'h4, 32'h1001, 1'b0, 1'b0);
      @(negedge clk);
      check("jalr_rpc", redirect_pc, 32'h1004);
      wait_idle();
      do_op(2, 3'b000, 32'h0, 32'h4, 32'h1002, 1'b0, 1'b0);
      @(negedge clk);
      check("jalr_mis", {31'd0, misaligned}, 32'd1);
      check("jalr_mis_no_rv", {31'd0, redirect_valid}, 32'd0);
      @(negedge clk);
      check("jalr_mis_pulse_end", {31'd0, misaligned}, 32'd0);

      // Stalled redirect with competing in_valid
      redirect_ready = 1'b0;
      do_op(1, 3'b000, 32'h200, 32'h40, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; is_jal = 1'b0; is_branch = 1'b1;
         funct3 = 3'b000; eq = 1'b1; pc = 32'h800; imm = 32'h8;
         @(negedge clk);
         check("stall_rv", {31'd0, redirect_valid}, 32'd1);
         check("stall_rpc", redirect_pc, 32'h240);
         @(posedge clk); #2;
      end
      in_valid = 1'b0;
      redirect_ready = 1'b1;
      wait_idle();

      // Illegal encoding, then wrapping BNE
      do_op(0, 3'b010, 32'h500, 32'h10, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      check("illegal_pulse", {31'd0, illegal_branch}, 32'd1);
      check("illegal_no_rv", {31'd0, redirect_valid}, 32'd0);
      do_op(0, 3'b001, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      check("wrap_rpc", redirect_pc, 32'h0000_0010);
      wait_idle();

      // Reset during FLUSH
      do_op(0, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0);
      @(posedge clk); #2;
      check("flush_kill_before_rst", {31'd0, kill}, 32'd1);
      reset_n = 1'b0;
      @(posedge clk); #2;
      check("rst_flush_kill", {31'd0, kill}, 32'd0);
      check("rst_flush_rv", {31'd0, redirect_valid}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_flush_idle", {31'd0, in_ready}, 32'd1);

      // Three ops, two taken (one of them misaligned)
      do_op(0, 3'b000, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0);
      wait_idle();
      do_op(1, 3'b000, 32'h300, 32'h8, 32'h0, 1'b0, 1'b0);
      wait_idle();
      do_op(1, 3'b000, 32'h0, 32'h2, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
`ifdef BRANCH_PERF_EN
      check("perf_resolved", resolved_count, 32'd3);
      check("perf_taken", taken_count, 32'd2);
`else
      check("perf_resolved_tied", resolved_count, 32'd0);
      check("perf_taken_tied", taken_count, 32'd0);
`endif

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         int kind;
         @(posedge clk); #2;
         kind           = $urandom_range(0, 2);
         reset_n        = ($urandom_range(0, 79) != 0);
         in_valid       = $urandom_range(0, 1);
         is_branch      = (kind == 0);
         is_jal         = (kind == 1);
         is_jalr        = (kind == 2);
         funct3         = 3'($urandom_range(0, 7));
         eq             = $urandom_range(0, 1);
         lt             = $urandom_range(0, 1);
         redirect_ready = ($urandom_range(0, 3) != 0);
         pc             = $urandom & 32'hFFFF_FFFC;
         imm            = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         rs1d           = $urandom;
      end
      @(posedge clk); #2;
      in_valid = 1'b0;
      reset_n  = 1'b1;
      redirect_ready = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter KILL_CYCLES, default 2, number of cycles kill is held after a redirect is accepted (0..7).
REQ-002 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  branch/jump operands valid this cycle.
- in_ready  output  1  block can accept an op.
- is_branch  input  1  conditional branch.
- is_jal  input  1  JAL.
- is_jalr  input  1  JALR.
- funct3  input  3  branch condition encoding.
- pc  input  32  instruction PC.
- imm  input  32  sign-extended immediate.
- rs1d  input  32  rs1 data, used for the JALR base.
- s  output  1  signed-compare select driven to Comparator.
- eq  input  1  Comparator equal flag.
- lt  input  1  Comparator less-than flag.
- redirect_valid  output  1  redirect request to fetch.
- redirect_ready  input  1  fetch accepts redirect.
- redirect_pc  output  32  redirect target.
- kill  output  1  squash younger instructions.
- misaligned  output  1  one-cycle pulse, taken target not word-aligned.
- illegal_branch  output  1  one-cycle pulse, funct3 is 010 or 011.
- resolved_count  output  32  perf counter.
- taken_count  output  32  perf counter.

Function
REQ-003 s SHALL be combinational from funct3: 0 for 110 and 111, otherwise 1.
REQ-004 taken SHALL be decided as follows:
- 000: eq.
- 001: !eq.
- 100 and 110: lt.
- 101 and 111: !lt.
- 010 and 011: not taken.
- is_jal or is_jalr: always taken.
REQ-005 The target SHALL be pc+imm for branch and JAL, and (rs1d+imm) with bit 0 cleared for JALR; all additions wrap modulo 2^32.
REQ-006 Exactly one of is_branch, is_jal or is_jalr SHALL be asserted with in_valid; if none is set, the op is accepted and ignored.
REQ-007 The FSM SHALL have the states IDLE, REDIRECT and FLUSH.
REQ-008 in_ready SHALL be 1 only in IDLE; an op is accepted when in_valid && in_ready.
REQ-009 Accept, taken, target[1]==0: the block SHALL register the target into redirect_pc and enter REDIRECT next cycle; redirect_valid goes high one cycle after acceptance.
REQ-010 Accept, taken, target[1]==1: misaligned SHALL pulse next cycle, with no redirect; the FSM stays IDLE.
REQ-011 Accept, not taken: the FSM SHALL stay IDLE and issue no redirect.
REQ-012 Accept of an illegal funct3: illegal_branch SHALL pulse next cycle.
REQ-013 In REDIRECT, redirect_valid and redirect_pc SHALL hold stable until redirect_ready is high.
REQ-014 On the redirect handshake:
- KILL_CYCLES>0: enter FLUSH with kill=1 for exactly KILL_CYCLES cycles, then return to IDLE.
- KILL_CYCLES==0: go directly to IDLE.
REQ-015 in_valid SHALL be ignored outside IDLE; no op is queued.
REQ-016 redirect_ready SHALL be ignored outside REDIRECT.
REQ-017 If redirect_ready is already high in the first REDIRECT cycle, the handshake SHALL complete in that same cycle.

Reset
REQ-018 While reset_n==0 at a clock edge, the block SHALL:
- enter IDLE.
- clear redirect_valid, kill, misaligned, illegal_branch, redirect_pc and both counters to 0.
- drive in_ready 0 during reset.
REQ-019 Reset during REDIRECT or FLUSH SHALL abort the operation at that edge, with no residual kill or redirect.

Configuration
REQ-020 With BRANCH_PERF_EN defined, the counters SHALL count as follows:
- resolved_count increments on every accepted op.
- taken_count increments on every accepted taken op, including misaligned ones.
- Both wrap at 2^32.
REQ-021 Without BRANCH_PERF_EN, the counter ports SHALL remain present and be tied to 0, and no counter flops are synthesized.

Structure
REQ-022 A shared package branch_defs SHALL hold the funct3 encodings, the FSM state encodings and the counter width.
REQ-023 Condition decode (REQ-003/004) SHALL live in one combinational sub-module, branch_cond.
REQ-024 Target arithmetic and the FSM SHALL stay in branch_resolver; Comparator remains external.

Verification
REQ-025 The bench SHALL cover these scenarios:
- BEQ, eq=1, pc=0x100, imm=0x20, redirect_ready=1 -> redirect_valid high the next cycle with redirect_pc=0x120, then kill high 2 cycles, then in_ready=1.
- BLTU, funct3=110 -> s=0; lt=0 -> no redirect and in_ready stays 1.
- JALR, rs1d=0x1001, imm=0x4 -> redirect_pc=0x1004 (bit 0 cleared); JALR with target 0x1006 -> misaligned pulse and no redirect.
- Redirect with redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable; a new in_valid during that time is ignored.
- funct3=010 -> illegal_branch pulse; pc=0xFFFFFFF0, imm=0x20, BNE eq=0 -> redirect_pc=0x00000010 (wrap).
- reset_n=0 during FLUSH -> kill=0 and IDLE next cycle; with BRANCH_PERF_EN, 3 ops (2 taken) -> resolved_count=3, taken_count=2.
